// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : stack_unit
// Description : Hardware LIFO stack for the PUSH/POP instructions of the
//               pipelined MIPS core. It sits in the memory stage and returns
//               the top-of-stack word to the datapath's memory-source mux.
//               It tracks occupancy and keeps sticky overflow/underflow flags.
//
// Ports       :
//   CLK            in   system clock, rising edge
//   RST            in   asynchronous active-low reset
//   PushM          in   push strobe (memory stage)
//   PopM           in   pop strobe (memory stage)
//   WriteData      in   [WIDTH]  word to push (memory-stage store data)
//   ErrClr         in   synchronous clear of Overflow/Underflow
//   StackReadData  out  [WIDTH]  current top of stack, 0 when empty (comb.)
//   Count          out  [$clog2(DEPTH)+1]  valid entries, 0..DEPTH
//   Full           out  Count == DEPTH
//   Empty          out  Count == 0
//   Overflow       out  sticky, push rejected while full
//   Underflow      out  sticky, pop while empty
//
// Revision    : 1.0 - initial release
// ============================================================================
module stack_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       PushM,
    input  logic                       PopM,
    input  logic [WIDTH-1:0]           WriteData,
    input  logic                       ErrClr,
    output logic [WIDTH-1:0]           StackReadData,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Full,
    output logic                       Empty,
    output logic                       Overflow,
    output logic                       Underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_wr_idx;
    logic             w_wr_en;
    logic             w_inc;
    logic             w_dec;
    logic             w_ovf_set;
    logic             w_unf_set;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // Low bits of Count minus one; when Count == DEPTH the low bits are zero
    // and the subtraction wraps to DEPTH-1, which is exactly the top slot.
    assign w_top_idx = r_count[AW-1:0] - AW'(1);

    // Write happens on a plain push that fits, or on any push+pop
    // (replace-top when non-empty, write slot 0 when empty).
    assign w_wr_en  = PushM & (PopM | ~w_full);
    assign w_wr_idx = (PopM & ~w_empty) ? w_top_idx : r_count[AW-1:0];

    // Push+pop on an empty stack behaves as a push (Count 0 -> 1).
    assign w_inc = PushM & ~w_full & (~PopM | w_empty);
    assign w_dec = PopM & ~PushM & ~w_empty;

    assign w_ovf_set = PushM & ~PopM & w_full;
    assign w_unf_set = PopM & w_empty;

    // Storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= WriteData;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_inc) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_dec) begin
                r_count <= r_count - (AW+1)'(1);
            end

            // A new error event in the same cycle as ErrClr keeps the flag set.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (ErrClr) begin
                r_overflow <= 1'b0;
            end

            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (ErrClr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // Not gated by PopM so the datapath can latch the popped word in the
    // same cycle the pop strobe is high.
    assign StackReadData = w_empty ? '0 : r_mem[w_top_idx];
    assign Count         = r_count;
    assign Full          = w_full;
    assign Empty         = w_empty;
    assign Overflow      = r_overflow;
    assign Underflow     = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_unit
// Description : Self-checking bench for stack_unit (DEPTH=4, WIDTH=32).
//               Each directed step records the outputs expected during that
//               cycle; a monitor compares them on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_unit;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] wdata;
    logic             errclr;
    logic [WIDTH-1:0] rdata;
    logic [2:0]       count;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             unf;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic [2:0]  cnt;
        logic        full;
        logic        empty;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK           (clk),
        .RST           (rst_n),
        .PushM         (push),
        .PopM          (pop),
        .WriteData     (wdata),
        .ErrClr        (errclr),
        .StackReadData (rdata),
        .Count         (count),
        .Full          (full),
        .Empty         (empty),
        .Overflow      (ovf),
        .Underflow     (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string field,
                       input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, field, act, expv);
        end
    endtask

    // Monitor: outputs are always presented, so one expectation is consumed
    // per falling edge whenever one is pending.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "rd",    rdata, e.rd);
            chk(e.name, "count", {29'd0, count}, {29'd0, e.cnt});
            chk(e.name, "full",  {31'd0, full},  {31'd0, e.full});
            chk(e.name, "empty", {31'd0, empty}, {31'd0, e.empty});
            chk(e.name, "ovf",   {31'd0, ovf},   {31'd0, e.ovf});
            chk(e.name, "unf",   {31'd0, unf},   {31'd0, e.unf});
        end
    end

    // Drive one cycle of stimulus and record the outputs expected during it
    // (state before this cycle's edge takes effect).
    task automatic step(input string nm, input logic pu, input logic po,
                        input logic [31:0] wd, input logic clr,
                        input logic [31:0] e_rd, input logic [2:0] e_cnt,
                        input logic e_ovf, input logic e_unf);
        exp_t e;
        @(posedge clk);
        #1;
        push   = pu;
        pop    = po;
        wdata  = wd;
        errclr = clr;
        e.name  = nm;
        e.rd    = e_rd;
        e.cnt   = e_cnt;
        e.full  = (e_cnt == 3'd4);
        e.empty = (e_cnt == 3'd0);
        e.ovf   = e_ovf;
        e.unf   = e_unf;
        q.push_back(e);
    endtask

    // Assert reset between edges; the monitor samples on the following
    // falling edge, before any rising edge could act on it.
    task automatic reset_mid(input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        push = 0; pop = 0; errclr = 0;
        #2;
        rst_n = 1'b0;
        e.name = nm; e.rd = 32'h0; e.cnt = 3'd0;
        e.full = 1'b0; e.empty = 1'b1; e.ovf = 1'b0; e.unf = 1'b0;
        q.push_back(e);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        push   = 0;
        pop    = 0;
        wdata  = '0;
        errclr = 0;
        #12;
        rst_n  = 1'b1;

        //   name       pu po wd       clr  rd        cnt ov un
        // 1. reset / idle
        step("reset",   0, 0, 32'h0,  0,   32'h0,    0,  0, 0);
        // 2. push three, pop three
        step("p11",     1, 0, 32'h11, 0,   32'h0,    0,  0, 0);
        step("p22",     1, 0, 32'h22, 0,   32'h11,   1,  0, 0);
        step("p33",     1, 0, 32'h33, 0,   32'h22,   2,  0, 0);
        step("pop33",   0, 1, 32'h0,  0,   32'h33,   3,  0, 0);
        step("pop22",   0, 1, 32'h0,  0,   32'h22,   2,  0, 0);
        step("pop11",   0, 1, 32'h0,  0,   32'h11,   1,  0, 0);
        step("empty2",  0, 0, 32'h0,  0,   32'h0,    0,  0, 0);
        // 3. fill, overflow, clear
        step("pA0",     1, 0, 32'hA0, 0,   32'h0,    0,  0, 0);
        step("pA1",     1, 0, 32'hA1, 0,   32'hA0,   1,  0, 0);
        step("pA2",     1, 0, 32'hA2, 0,   32'hA1,   2,  0, 0);
        step("pA3",     1, 0, 32'hA3, 0,   32'hA2,   3,  0, 0);
        step("pFF",     1, 0, 32'hFF, 0,   32'hA3,   4,  0, 0);
        step("ovf",     0, 0, 32'h0,  0,   32'hA3,   4,  1, 0);
        step("clrovf",  0, 0, 32'h0,  1,   32'hA3,   4,  1, 0);
        step("ovfclr",  0, 0, 32'h0,  0,   32'hA3,   4,  0, 0);
        step("drain3",  0, 1, 32'h0,  0,   32'hA3,   4,  0, 0);
        step("drain2",  0, 1, 32'h0,  0,   32'hA2,   3,  0, 0);
        step("drain1",  0, 1, 32'h0,  0,   32'hA1,   2,  0, 0);
        step("drain0",  0, 1, 32'h0,  0,   32'hA0,   1,  0, 0);
        // 4. underflow, set wins over clear
        step("popE",    0, 1, 32'h0,  0,   32'h0,    0,  0, 0);
        step("unf",     0, 0, 32'h0,  0,   32'h0,    0,  0, 1);
        step("popEclr", 0, 1, 32'h0,  1,   32'h0,    0,  0, 1);
        step("unfkeep", 0, 0, 32'h0,  1,   32'h0,    0,  0, 1);
        step("unfclr",  0, 0, 32'h0,  0,   32'h0,    0,  0, 0);
        // 5. simultaneous push+pop
        step("p5",      1, 0, 32'h5,  0,   32'h0,    0,  0, 0);
        step("p6",      1, 0, 32'h6,  0,   32'h5,    1,  0, 0);
        step("pp9",     1, 1, 32'h9,  0,   32'h6,    2,  0, 0);
        step("top9",    0, 1, 32'h0,  0,   32'h9,    2,  0, 0);
        step("pop5",    0, 1, 32'h0,  0,   32'h5,    1,  0, 0);
        step("ppE9",    1, 1, 32'h9,  0,   32'h0,    0,  0, 0);
        step("ppEres",  0, 0, 32'h0,  1,   32'h9,    1,  0, 1);
        step("pop9",    0, 1, 32'h0,  0,   32'h9,    1,  0, 0);
        step("empty5",  0, 0, 32'h0,  0,   32'h0,    0,  0, 0);
        // 6. asynchronous reset mid-operation
        step("p77",     1, 0, 32'h77, 0,   32'h0,    0,  0, 0);
        step("p88",     1, 0, 32'h88, 0,   32'h77,   1,  0, 0);
        step("top88",   0, 0, 32'h0,  0,   32'h88,   2,  0, 0);
        reset_mid("arst");
        step("popRst",  0, 1, 32'h0,  0,   32'h0,    0,  0, 0);
        step("unfRst",  0, 0, 32'h0,  0,   32'h0,    0,  0, 1);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
